// File: rtl/reg_file_if.sv
// ----------------------------------------------------------------------------
// reg_file_if
//
// Purpose:
//   Bundles the three traffic groups that meet at the architectural register
//   file into one interface:
//     - issue  : the decoder marks a destination as pending on a ROB tag
//     - commit : the ROB writes a retired value and retires its tag
//     - read   : the decoder looks up two source operands combinationally
//
// Modports:
//   master : the pipeline side (decoder + ROB). Drives issue/commit/read
//            indices and receives operand value + dependency tag.
//   slave  : the register file. Receives issue/commit/read indices and
//            drives operand value + dependency tag.
//
// Tags are ROB_POS_WIDTH+1 bits wide. MSB=1 marks a live tag, and an
// all-zero tag means "no dependency".
// ----------------------------------------------------------------------------
interface reg_file_if #(
    parameter int ROB_POS_WIDTH = 4
);
    localparam int TAG_W = ROB_POS_WIDTH + 1;

    // Issue: destination of a newly dispatched instruction.
    logic             issue_to_reg_enable;
    logic [4:0]       issue_to_reg_rd;
    logic [TAG_W-1:0] issue_to_reg_rob_pos;

    // Commit: retirement write from the ROB head.
    logic             rob_to_reg_enable;
    logic [4:0]       rob_to_reg_rd;
    logic [31:0]      rob_to_reg_val;
    logic [TAG_W-1:0] commit_rob_pos;

    // Decoder operand lookup.
    logic [4:0]       dc_to_reg_rs1;
    logic [4:0]       dc_to_reg_rs2;
    logic [31:0]      reg_to_dc_rs1_val;
    logic [TAG_W-1:0] reg_to_dc_rs1_dep;
    logic [31:0]      reg_to_dc_rs2_val;
    logic [TAG_W-1:0] reg_to_dc_rs2_dep;

    modport master (
        output issue_to_reg_enable, issue_to_reg_rd, issue_to_reg_rob_pos,
        output rob_to_reg_enable, rob_to_reg_rd, rob_to_reg_val, commit_rob_pos,
        output dc_to_reg_rs1, dc_to_reg_rs2,
        input  reg_to_dc_rs1_val, reg_to_dc_rs1_dep,
        input  reg_to_dc_rs2_val, reg_to_dc_rs2_dep
    );

    modport slave (
        input  issue_to_reg_enable, issue_to_reg_rd, issue_to_reg_rob_pos,
        input  rob_to_reg_enable, rob_to_reg_rd, rob_to_reg_val, commit_rob_pos,
        input  dc_to_reg_rs1, dc_to_reg_rs2,
        output reg_to_dc_rs1_val, reg_to_dc_rs1_dep,
        output reg_to_dc_rs2_val, reg_to_dc_rs2_dep
    );
endinterface

// File: rtl/reg_file.sv
// ----------------------------------------------------------------------------
// reg_file
//
// Purpose:
//   Architectural register file with per-register rename tags. Each register
//   holds a 32-bit committed value and the wrapped ROB tag of its youngest
//   in-flight producer (0 when the value is final). Issue records a producer,
//   commit writes the value and retires the tag if it still belongs to the
//   committing entry, and a flush drops every pending tag.
//
// Ports:
//   clk  : clock
//   rst  : asynchronous active-low reset; clears all values and tags
//   rdy  : global ready; low freezes all state (flush included)
//   clr  : ROB flush; drops all pending tags, blocks same-cycle issue,
//          still honours same-cycle commit
//   bus  : reg_file_if.slave carrying issue, commit and decoder read ports
//
// Reads are purely combinational, with a same-cycle commit bypass and no
// same-cycle issue bypass (an instruction must see the mapping that existed
// before its own issue). x0 reads as zero and ignores writes/issues.
// ----------------------------------------------------------------------------
module reg_file #(
    parameter int REG_NUM       = 32,
    parameter int ROB_POS_WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rdy,
    input  logic           clr,
    reg_file_if.slave      bus
);
    localparam int TAG_W = ROB_POS_WIDTH + 1;

    typedef logic [TAG_W-1:0] tag_t;

    // Result of one operand lookup.
    typedef struct packed {
        logic [31:0] val;
        tag_t        dep;
    } rd_res_t;

    // ------------------------------------------------------------------
    // Local views of the interface signals
    // ------------------------------------------------------------------
    logic        issue_en;
    logic [4:0]  issue_rd;
    tag_t        issue_pos;
    logic        commit_en;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val;
    tag_t        commit_pos;

    assign issue_en   = bus.issue_to_reg_enable;
    assign issue_rd   = bus.issue_to_reg_rd;
    assign issue_pos  = bus.issue_to_reg_rob_pos;
    assign commit_en  = bus.rob_to_reg_enable;
    assign commit_rd  = bus.rob_to_reg_rd;
    assign commit_val = bus.rob_to_reg_val;
    assign commit_pos = bus.commit_rob_pos;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]        val_q   [REG_NUM];
    tag_t               tag_q   [REG_NUM];
    tag_t               tag_nxt [REG_NUM];
    logic [REG_NUM-1:0] wr_en;

    // ------------------------------------------------------------------
    // Next-state tag and value-write decode
    // ------------------------------------------------------------------
    // Tag priority per register: flush clears everything, then a new issue
    // takes over (it is younger than anything committing), and only then
    // does a matching commit retire the tag. A commit whose tag no longer
    // matches leaves the younger producer's tag in place.
    always_comb begin
        for (int i = 0; i < REG_NUM; i++) begin
            // NOTE: every signal written here gets a default first, so no
            // path leaves it unassigned and no latch is inferred.
            wr_en[i]   = 1'b0;
            tag_nxt[i] = tag_q[i];
            if (i != 0) begin
                wr_en[i] = commit_en && (commit_rd == 5'(i));
                if (clr) begin
                    tag_nxt[i] = '0;
                end else if (issue_en && (issue_rd == 5'(i))) begin
                    tag_nxt[i] = issue_pos;
                end else if (wr_en[i] && (tag_q[i] == commit_pos)) begin
                    tag_nxt[i] = '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: this array is built from flops, not a RAM macro, so it can and
    // must be cleared by reset: consumers rely on every tag reading 0 after
    // reset, otherwise stale tags would stall the decoder forever.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (rdy) begin
            // NOTE: non-blocking assignments keep every register update
            // based on pre-edge values, independent of statement order.
            for (int i = 0; i < REG_NUM; i++) begin
                if (wr_en[i]) begin
                    val_q[i] <= commit_val;
                end
                tag_q[i] <= tag_nxt[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Combinational read path
    // ------------------------------------------------------------------
    // A committing value is forwarded only when its tag is still the one the
    // register is waiting on; if a younger producer has been issued, the
    // reader must wait on that producer instead. During a flush every
    // in-flight producer is gone, so the stored value is final.
    function automatic rd_res_t read_reg(input logic [4:0] rs);
        rd_res_t res;
        res.val = '0;
        res.dep = '0;
        if ((rs != 5'd0) && (int'(rs) < REG_NUM)) begin
            if (commit_en && (commit_rd == rs) && (tag_q[rs] == commit_pos)) begin
                res.val = commit_val;
            end else begin
                res.val = val_q[rs];
                res.dep = clr ? '0 : tag_q[rs];
            end
        end
        return res;
    endfunction

    rd_res_t rs1_res;
    rd_res_t rs2_res;

    always_comb begin
        rs1_res = read_reg(bus.dc_to_reg_rs1);
        rs2_res = read_reg(bus.dc_to_reg_rs2);
    end

    assign bus.reg_to_dc_rs1_val = rs1_res.val;
    assign bus.reg_to_dc_rs1_dep = rs1_res.dep;
    assign bus.reg_to_dc_rs2_val = rs2_res.val;
    assign bus.reg_to_dc_rs2_dep = rs2_res.dep;

endmodule

// File: tb/tb_reg_file.sv
// ----------------------------------------------------------------------------
// tb_reg_file
//
// Directed bench for reg_file: a linear sequence of issue/commit/flush/
// ready/reset scenarios, each followed by operand reads compared against
// hand-computed value/dependency pairs.
// ----------------------------------------------------------------------------
module tb_reg_file;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic clr;

    int passed = 0;
    int total  = 0;

    reg_file_if #(.ROB_POS_WIDTH(4)) bus ();

    reg_file #(
        .REG_NUM       (32),
        .ROB_POS_WIDTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs and samples then sit mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name,
                         input logic [31:0] v_obs, input logic [4:0] d_obs,
                         input logic [31:0] v_exp, input logic [4:0] d_exp);
        total++;
        assert ({v_obs, d_obs} === {v_exp, d_exp}) passed++;
        else $error("FAIL %s: observed val=%h dep=%h, expected val=%h dep=%h",
                    name, v_obs, d_obs, v_exp, d_exp);
    endtask

    task automatic chk1(input string name, input logic [31:0] v, input logic [4:0] d);
        #1;
        check(name, bus.reg_to_dc_rs1_val, bus.reg_to_dc_rs1_dep, v, d);
    endtask

    task automatic chk2(input string name, input logic [31:0] v, input logic [4:0] d);
        #1;
        check(name, bus.reg_to_dc_rs2_val, bus.reg_to_dc_rs2_dep, v, d);
    endtask

    task automatic idle();
        bus.issue_to_reg_enable  = 1'b0;
        bus.issue_to_reg_rd      = 5'd0;
        bus.issue_to_reg_rob_pos = 5'h00;
        bus.rob_to_reg_enable    = 1'b0;
        bus.rob_to_reg_rd        = 5'd0;
        bus.rob_to_reg_val       = 32'h0;
        bus.commit_rob_pos       = 5'h00;
        clr                      = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [4:0] pos);
        bus.issue_to_reg_enable  = 1'b1;
        bus.issue_to_reg_rd      = rd;
        bus.issue_to_reg_rob_pos = pos;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [31:0] v, input logic [4:0] pos);
        bus.rob_to_reg_enable = 1'b1;
        bus.rob_to_reg_rd     = rd;
        bus.rob_to_reg_val    = v;
        bus.commit_rob_pos    = pos;
    endtask

    initial begin
        // -------- reset --------
        rst = 1'b0;
        rdy = 1'b1;
        idle();
        bus.dc_to_reg_rs1 = 5'd5;
        bus.dc_to_reg_rs2 = 5'd0;
        #12;
        chk1("reset_rs1_x5", 32'h0, 5'h00);
        chk2("reset_rs2_x0", 32'h0, 5'h00);
        rst = 1'b1;
        step();
        chk1("post_reset_x5", 32'h0, 5'h00);

        // -------- issue then commit with bypass --------
        issue(5'd3, 5'h12);
        step();
        idle();
        bus.dc_to_reg_rs1 = 5'd3;
        chk1("x3_pending", 32'h0, 5'h12);
        commit(5'd3, 32'hDEADBEEF, 5'h12);
        chk1("x3_commit_bypass", 32'hDEADBEEF, 5'h00);
        step();
        idle();
        chk1("x3_committed", 32'hDEADBEEF, 5'h00);

        // -------- stale commit keeps younger tag --------
        issue(5'd7, 5'h11);
        step();
        issue(5'd7, 5'h13);
        step();
        idle();
        commit(5'd7, 32'h1, 5'h11);
        bus.dc_to_reg_rs1 = 5'd7;
        chk1("x7_no_bypass_stale", 32'h0, 5'h13);
        step();
        idle();
        chk1("x7_val_written_tag_kept", 32'h1, 5'h13);

        // -------- same-cycle issue and commit to one register --------
        issue(5'd4, 5'h15);
        commit(5'd4, 32'h9, 5'h14);
        bus.dc_to_reg_rs2 = 5'd4;
        chk2("x4_no_issue_bypass", 32'h0, 5'h00);
        step();
        idle();
        chk2("x4_issue_beats_commit", 32'h9, 5'h15);

        // -------- flush with concurrent commit and issue --------
        commit(5'd2, 32'h55, 5'h00);
        step();
        idle();
        issue(5'd1, 5'h16);
        step();
        issue(5'd2, 5'h17);
        step();
        issue(5'd9, 5'h18);
        step();
        idle();
        bus.dc_to_reg_rs1 = 5'd2;
        chk1("x2_pending_before_clr", 32'h55, 5'h17);
        clr = 1'b1;
        commit(5'd1, 32'd42, 5'h16);
        issue(5'd2, 5'h1F);
        bus.dc_to_reg_rs1 = 5'd1;
        bus.dc_to_reg_rs2 = 5'd2;
        chk1("clr_x1_commit_bypass", 32'd42, 5'h00);
        chk2("clr_x2_dep_masked", 32'h55, 5'h00);
        step();
        idle();
        chk1("after_clr_x1", 32'd42, 5'h00);
        chk2("after_clr_x2_issue_dropped", 32'h55, 5'h00);
        bus.dc_to_reg_rs1 = 5'd7;
        bus.dc_to_reg_rs2 = 5'd9;
        chk1("after_clr_x7", 32'h1, 5'h00);
        chk2("after_clr_x9", 32'h0, 5'h00);

        // -------- x0 is immutable --------
        issue(5'd0, 5'h1A);
        commit(5'd0, 32'd77, 5'h00);
        bus.dc_to_reg_rs1 = 5'd0;
        chk1("x0_no_bypass", 32'h0, 5'h00);
        step();
        idle();
        chk1("x0_after_write", 32'h0, 5'h00);

        // -------- rdy low freezes state --------
        rdy = 1'b0;
        issue(5'd6, 5'h1B);
        commit(5'd5, 32'h123, 5'h00);
        step();
        idle();
        rdy = 1'b1;
        bus.dc_to_reg_rs1 = 5'd6;
        bus.dc_to_reg_rs2 = 5'd5;
        chk1("rdy_low_no_issue", 32'h0, 5'h00);
        chk2("rdy_low_no_commit", 32'h0, 5'h00);

        // -------- asynchronous reset mid-operation --------
        issue(5'd10, 5'h1C);
        commit(5'd11, 32'h5, 5'h00);
        step();
        idle();
        bus.dc_to_reg_rs1 = 5'd10;
        bus.dc_to_reg_rs2 = 5'd11;
        chk1("x10_pending", 32'h0, 5'h1C);
        chk2("x11_written", 32'h5, 5'h00);
        #1;
        rst = 1'b0;
        chk1("async_reset_x10", 32'h0, 5'h00);
        chk2("async_reset_x11", 32'h0, 5'h00);
        bus.dc_to_reg_rs1 = 5'd3;
        chk1("async_reset_x3", 32'h0, 5'h00);
        rst = 1'b1;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file with per-register rename tags.
- Sits directly downstream of the reorder buffer's commit port and beside the decoder.
- Issue marks a destination register as pending on a ROB entry. ROB commit writes the value and retires the tag.
- Decoder reads operand value plus dependency tag combinationally, with same-cycle commit bypass.

Parameters:
- REG_NUM, 32, number of architectural registers (x0 hardwired zero).
- ROB_POS_WIDTH, 4, ROB index width; wrapped tag width is ROB_POS_WIDTH+1.
- Wrapped tag format: MSB=1 means valid tag; 0 means no dependency.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- rdy  in  1  global ready; low freezes all state
- clr  in  1  flush from ROB; drops all pending tags
- issue_to_reg_enable  in  1  decoded instruction with rd issued this cycle
- issue_to_reg_rd  in  5  destination register
- issue_to_reg_rob_pos  in  ROB_POS_WIDTH+1  wrapped ROB tag of issued instr (MSB=1)
- rob_to_reg_enable  in  1  commit write strobe
- rob_to_reg_rd  in  5  commit destination
- rob_to_reg_val  in  32  commit value
- commit_rob_pos  in  ROB_POS_WIDTH+1  wrapped tag of committing entry
- dc_to_reg_rs1  in  5  decoder source 1 index
- dc_to_reg_rs2  in  5  decoder source 2 index
- reg_to_dc_rs1_val  out  32  source 1 value (valid when dep=0)
- reg_to_dc_rs1_dep  out  ROB_POS_WIDTH+1  source 1 producer tag, 0 if none
- reg_to_dc_rs2_val  out  32  source 2 value
- reg_to_dc_rs2_dep  out  ROB_POS_WIDTH+1  source 2 producer tag

Behaviour:
- State: val[REG_NUM] of 32 bits, tag[REG_NUM] of ROB_POS_WIDTH+1 bits.
- Reset: rst low asynchronously clears all val and tag to 0. All read outputs then evaluate to 0.
- rdy low (rst high): no state change, clr included. Read outputs remain combinational on current state.
- Commit, on posedge with rob_to_reg_enable=1 and rob_to_reg_rd!=0:
  - val[rd] <= rob_to_reg_val.
  - tag[rd] <= 0 only if tag[rd]==commit_rob_pos; otherwise the tag is kept (a younger producer exists).
  - Commit is honoured even when clr=1 in the same cycle (JALR commit coincides with flush).
- Issue, on posedge with issue_to_reg_enable=1, clr=0, rd!=0: tag[rd] <= issue_to_reg_rob_pos.
- Issue and commit to the same rd in the same cycle: value written, tag = issue tag. Issue has priority over commit tag-clear.
- clr=1: every tag <= 0; issue that cycle ignored; values untouched except the commit write.
- x0: writes and issues to rd=0 are discarded; reads of x0 return val=0, dep=0.
- Read path, purely combinational, zero latency, identical for rs1/rs2:
  - Commit bypass: if rob_to_reg_enable && rob_to_reg_rd==rs && rs!=0 && tag[rs]==commit_rob_pos, return val=rob_to_reg_val, dep=0.
  - Else if clr=1: return val[rs], dep=0.
  - Else return val[rs], tag[rs].
  - No bypass from same-cycle issue: the reader sees the mapping before its own issue.
- Tag compare uses the full ROB_POS_WIDTH+1 bits; wrap is handled by the ROB, no arithmetic here.
- Reset asserted mid-operation: state clears immediately regardless of clk/rdy.

Test Plan:
- Reset then read rs1=5, rs2=0 -> val=0, dep=0 on both; after rst release, state holds 0.
- Issue rd=3 tag=5'h12; next cycle read rs1=3 -> dep=5'h12. Commit rd=3 val=32'hDEADBEEF pos=5'h12 -> same-cycle read gives val DEADBEEF dep 0; next cycle tag=0, val DEADBEEF.
- Issue rd=7 tag 5'h11, then issue rd=7 tag 5'h13; commit rd=7 pos 5'h11 val 1 -> val[7]=1, dep stays 5'h13. Read bypass is not applied.
- Same cycle: issue rd=4 tag 5'h15 and commit rd=4 pos 5'h14 val 9 -> val[4]=9, tag[4]=5'h15.
- Tags on x1,x2,x9; assert clr with commit rd=1 val 42 pos matching plus issue rd=2 tag 5'h1F -> all tags 0, x1=42, x2 value unchanged and untagged.
- Issue/commit rd=0 val 77 -> x0 reads 0, dep 0. With rdy=0, issue rd=6 -> no tag change.
